// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file with post-reset clear walk; define REGFILE_BYPASS_EN for write-to-read forwarding
module reg_file_2r1w #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              LoadReg,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  reg_in,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  reg_outA,
  output logic [WIDTH-1:0]  reg_outB,
  output logic              ready
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_ready, w_ready_nxt;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_last, w_clearing, w_we;
  logic [ADDR_W-1:0] w_wa;
  logic [WIDTH-1:0]  w_wd;
  assign w_last     = r_ptr == ADDR_W'(DEPTH - 1);
  assign w_clearing = CLR || r_state == CLEAR;
  // Clear walk advances one entry per edge and hands over to RUN after the last entry
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_ready_nxt = r_ready;
    if (r_state == CLEAR) begin
      w_ptr_nxt   = r_ptr + 1'b1;
      w_state_nxt = w_last ? RUN : CLEAR;
      w_ready_nxt = w_last;
    end
  end
  // Reset restarts the walk from entry 0 regardless of current state
  always_ff @(posedge clk) begin
    if (CLR) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ready <= w_ready_nxt;
    end
  end
  // Single write port shared by reset, clear walk and user writes; user writes only land in RUN
  always_comb begin
    w_we = w_clearing || (r_state == RUN && LoadReg);
    w_wa = CLR ? '0 : r_state == CLEAR ? r_ptr : WrAddr;
    w_wd = w_clearing ? '0 : reg_in;
  end
  // Storage update
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
  end
  assign ready = r_ready;
`ifdef REGFILE_BYPASS_EN
  logic w_fwd_a, w_fwd_b;
  assign w_fwd_a  = LoadReg && RdAddrA == WrAddr;
  assign w_fwd_b  = LoadReg && RdAddrB == WrAddr;
  assign reg_outA = !r_ready ? '0 : w_fwd_a ? reg_in : r_mem[RdAddrA];
  assign reg_outB = !r_ready ? '0 : w_fwd_b ? reg_in : r_mem[RdAddrB];
`else
  assign reg_outA = r_ready ? r_mem[RdAddrA] : '0;
  assign reg_outB = r_ready ? r_mem[RdAddrB] : '0;
`endif
endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised successor to the 8×16 single-port register file in the CPU datapath. It holds 2**ADDR_W words of WIDTH bits and has two independent combinational read ports (A and B), so both ALU operands are fetched in the same cycle, plus one write port. A synchronous active-high reset starts a sequential clear walk that zeroes every entry, one per cycle; `ready` gates the datapath until the walk is complete. An optional write-to-read bypass is compiled in with a macro.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (1..8)

Ports:
- clk  in  1  clock; all state updates on rising edge
- CLR  in  1  reset; synchronous, active-high. The clock is one clock domain; reset is synchronous and active-high.
- LoadReg  in  1  write enable
- WrAddr  in  ADDR_W  write address
- reg_in  in  WIDTH  write data
- RdAddrA  in  ADDR_W  read address, port A
- RdAddrB  in  ADDR_W  read address, port B
- reg_outA  out  WIDTH  read data, port A (combinational)
- reg_outB  out  WIDTH  read data, port B (combinational)
- ready  out  1  registered; high when clear is done and the file accepts writes

## Operation
- States: CLEAR and RUN, with clear pointer `ptr` (ADDR_W bits).
- CLR=1 at an edge:
  - state←CLEAR, ptr←0, ready←0.
  - mem[0]←0.
  - Any other write is discarded.
  - Takes priority over everything else, including mid-clear and mid-write.
- CLEAR with CLR=0 at an edge:
  - mem[ptr]←0, ptr←ptr+1.
  - If ptr==DEPTH-1: state←RUN, ready←1, and ptr wraps to 0.
- RUN with LoadReg=1 at an edge: mem[WrAddr]←reg_in.
- RUN with LoadReg=0: no change.
- LoadReg is ignored while ready=0. The write is dropped, not queued.
- Read outputs:
  - reg_outX = mem[RdAddrX] when ready=1, otherwise all-zero.
  - Both ports are fully independent; they may use equal or different addresses.
- Same-address write and read in one cycle without bypass: reg_outX shows the old value until the write edge, then the new value.
- Width rules:
  - No arithmetic on data; reg_in is stored verbatim.
  - ptr compares against DEPTH-1 at ADDR_W bits; no overflow state exists.
- Power-up before the first CLR:
  - Contents and state are undefined.
  - The system must assert CLR at least one cycle.

## Timing
- Reset values (after the CLR edge): ready=0, reg_outA=reg_outB=0, ptr=0.
- Clear latency:
  - Count the first edge with CLR=0 as edge 1.
  - ready rises at edge DEPTH (edge 16 for ADDR_W=4).
  - The first accepted write is on the edge after ready=1 is visible.
- Read latency: 0 cycles (combinational from RdAddrX and mem).
- Write latency: data is visible on a read port in the cycle after the write edge, or the same cycle with bypass.
- CLR held N cycles: clear completes DEPTH edges after CLR falls, independent of N.
- CLR re-asserted mid-clear or in RUN: the walk restarts from 0 and ready drops at that edge.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - When ready=1, LoadReg=1 and RdAddrX==WrAddr, reg_outX = reg_in combinationally in the same cycle.
  - Applies to each port independently.
  - Bypass is inactive while ready=0.
- Undefined:
  - No forwarding; same-cycle reads return the pre-write value.
  - No extra muxes are synthesised.

## Test plan
- Reset/clear: hold CLR=1 for 3 cycles, release.
  - ready=0 and both outputs 0 for edges 1-15.
  - ready=1 at edge 16.
  - Reads of all 16 addresses return 0x00.
- Write then dual read: ready=1; write 0xA5→r3 and 0x5A→r12.
  - Next cycle, RdAddrA=3 and RdAddrB=12 give reg_outA=0xA5, reg_outB=0x5A.
  - With RdAddrA=RdAddrB=3, both ports give 0xA5.
- Write while not ready: LoadReg=1, WrAddr=7, reg_in=0xFF at edge 5 of the clear.
  - After ready=1, r7 reads 0x00.
- Reset mid-operation: fill r0..r15 with 0x10+i, then pulse CLR for 1 cycle at an arbitrary point.
  - ready drops at the CLR edge.
  - After 16 edges all entries read 0x00.
  - Repeat with CLR asserted at clear edge 8: the walk restarts and ready rises 16 edges after release.
- Same-cycle read/write on r9 (old 0x11, new 0x22):
  - With REGFILE_BYPASS_EN, reg_outA=0x22 in the write cycle.
  - Without it, reg_outA=0x11 in the write cycle and 0x22 in the next cycle.
- Parameter sweep: WIDTH=16, ADDR_W=2.
  - ready rises at edge 4.
  - Write 0xBEEF→r3 and read back 0xBEEF.
  - Writing r0 while reading r3 leaves r3 at 0xBEEF.
